// File: rtl/lib_cntr_pkg.sv
// Shared constants for the lib counter bank: direction encoding, default sizes
// and a part-select helper for the flattened per-channel buses.
`ifndef LIB_CNTR_SLICE
`define LIB_CNTR_SLICE(idx, w) (idx)*(w) +: (w)
`endif

package lib_cntr_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_NCH   = 3;
    localparam int DEF_DIV_W = 4;

endpackage

// File: rtl/lib_cntr_chan.sv
// One counter channel: clear/load/count priority, terminal-count pulse and a
// sticky overflow flag.
module lib_cntr_chan
    import lib_cntr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    // Up mode wraps at or above the limit, so the only modulo wrap is the
    // down-count 0 -> limit reload; a count parked above limit decrements.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            unique case (dir_i)
                DIR_UP: begin
                    if (count_q >= limit_i) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                DIR_DN: begin
                    if (count_q == '0) begin
                        count_d = limit_i;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            endcase
        end
        ovf_d = clr_i ? 1'b0 : (ovf_q | tc_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/lib_cntr_bank.sv
// Bank of NCH counter channels with bypass muxing, plus a shadow-reloaded
// clock divider and a whole-pulse gated copy of the divided clock.
module lib_cntr_bank
    import lib_cntr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH-1:0]       CLR,
    input  logic [NCH-1:0]       LOAD,
    input  logic [NCH-1:0]       DIR,
    input  logic [NCH*WIDTH-1:0] LOAD_VAL,
    input  logic [NCH*WIDTH-1:0] LIMIT,
    input  logic [NCH-1:0]       SEL,
    input  logic [NCH*WIDTH-1:0] BYPASS,
    input  logic [DIV_W-1:0]     DIV,
    input  logic                 EN_G,
    output logic [NCH*WIDTH-1:0] CNTR_OUT,
    output logic [NCH-1:0]       TC,
    output logic [NCH-1:0]       OVF,
    output logic                 CLK_OUT_DIV,
    output logic                 CLK_OUT_G
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic [WIDTH-1:0] count;

        lib_cntr_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_i      (CLK),
            .rst_i      (RST),
            .en_i       (EN[i]),
            .clr_i      (CLR[i]),
            .load_i     (LOAD[i]),
            .dir_i      (DIR[i]),
            .load_val_i (LOAD_VAL[`LIB_CNTR_SLICE(i, WIDTH)]),
            .limit_i    (LIMIT[`LIB_CNTR_SLICE(i, WIDTH)]),
            .count_o    (count),
            .tc_o       (TC[i]),
            .ovf_o      (OVF[i])
        );

        assign CNTR_OUT[`LIB_CNTR_SLICE(i, WIDTH)] =
            SEL[i] ? count : BYPASS[`LIB_CNTR_SLICE(i, WIDTH)];
    end

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             clk_div_q;
    logic             en_q;
    logic             clk_g_q;
    logic             div_next;
    logic             en_next;

    // The gate decision is only refreshed while the divided clock is low,
    // so a high phase is either emitted whole or suppressed whole.
    always_comb begin
        div_next = clk_div_q ^ (div_cnt_q == div_q);
        en_next  = div_next ? en_q : EN_G;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt_q <= '0;
            div_q     <= '0;
            clk_div_q <= 1'b0;
            en_q      <= 1'b0;
            clk_g_q   <= 1'b0;
        end else begin
            if (div_cnt_q == div_q) begin
                div_cnt_q <= '0;
                div_q     <= DIV;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
            clk_div_q <= div_next;
            en_q      <= en_next;
            clk_g_q   <= div_next & en_next;
        end
    end

    assign CLK_OUT_DIV = clk_div_q;
    assign CLK_OUT_G   = clk_g_q;

endmodule

// File: tb/tb_lib_cntr_bank.sv
// Randomized bench for lib_cntr_bank: a behavioural model checked every cycle,
// plus directed sequences with hand-derived expected values.
module tb_lib_cntr_bank;

    localparam int WIDTH = 3;
    localparam int NCH   = 3;
    localparam int DIV_W = 4;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NCH-1:0]       EN, CLR, LOAD, DIR, SEL;
    logic [NCH*WIDTH-1:0] LOAD_VAL, LIMIT, BYPASS;
    logic [DIV_W-1:0]     DIV;
    logic                 EN_G;
    logic [NCH*WIDTH-1:0] CNTR_OUT;
    logic [NCH-1:0]       TC, OVF;
    logic                 CLK_OUT_DIV, CLK_OUT_G;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    lib_cntr_bank #(
        .WIDTH(WIDTH),
        .NCH  (NCH),
        .DIV_W(DIV_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .CLR        (CLR),
        .LOAD       (LOAD),
        .DIR        (DIR),
        .LOAD_VAL   (LOAD_VAL),
        .LIMIT      (LIMIT),
        .SEL        (SEL),
        .BYPASS     (BYPASS),
        .DIV        (DIV),
        .EN_G       (EN_G),
        .CNTR_OUT   (CNTR_OUT),
        .TC         (TC),
        .OVF        (OVF),
        .CLK_OUT_DIV(CLK_OUT_DIV),
        .CLK_OUT_G  (CLK_OUT_G)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] outSlice(input int i);
        return CNTR_OUT[i*WIDTH +: WIDTH];
    endfunction

    // Behavioural model: counts as plain integers, divider as "cycles left in
    // the current phase", gate as "EN_G seen on the last low-phase edge".
    int mCnt[NCH];
    bit mTc[NCH];
    bit mOvf[NCH];
    bit mDiv = 1'b0;
    bit mGate = 1'b0;
    bit lastEnLow = 1'b0;
    int phaseLeft = 1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                mCnt[i] = 0;
                mTc[i]  = 1'b0;
                mOvf[i] = 1'b0;
            end
            mDiv = 1'b0;
            mGate = 1'b0;
            lastEnLow = 1'b0;
            phaseLeft = 1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                int lim;
                lim = int'(LIMIT[i*WIDTH +: WIDTH]);
                mTc[i] = 1'b0;
                if (CLR[i]) begin
                    mCnt[i] = 0;
                    mOvf[i] = 1'b0;
                end else if (LOAD[i]) begin
                    mCnt[i] = int'(LOAD_VAL[i*WIDTH +: WIDTH]);
                end else if (EN[i]) begin
                    if (!DIR[i]) begin
                        if (mCnt[i] >= lim) begin
                            mCnt[i] = 0;
                            mTc[i] = 1'b1;
                        end else begin
                            mCnt[i] = mCnt[i] + 1;
                        end
                    end else begin
                        if (mCnt[i] == 0) begin
                            mCnt[i] = lim;
                            mTc[i] = 1'b1;
                        end else begin
                            mCnt[i] = mCnt[i] - 1;
                        end
                    end
                end
                if (mTc[i]) mOvf[i] = 1'b1;
            end
            phaseLeft = phaseLeft - 1;
            if (phaseLeft == 0) begin
                mDiv = !mDiv;
                phaseLeft = int'(DIV) + 1;
            end
            if (!mDiv) lastEnLow = EN_G;
            mGate = mDiv && lastEnLow;
        end
    end

    always @(negedge CLK) begin
        if (checkEn) begin
            for (int i = 0; i < NCH; i++) begin
                logic [WIDTH-1:0] expOut;
                expOut = SEL[i] ? WIDTH'(mCnt[i]) : BYPASS[i*WIDTH +: WIDTH];
                checkOutput($sformatf("model_tc%0d", i), TC[i], mTc[i]);
                checkOutput($sformatf("model_ovf%0d", i), OVF[i], mOvf[i]);
                checkOutput($sformatf("model_out%0d", i), outSlice(i), expOut);
            end
            checkOutput("model_div", CLK_OUT_DIV, mDiv);
            checkOutput("model_gate", CLK_OUT_G, mGate);
        end
    end

    task automatic applyStimulus();
        EN = NCH'($urandom);
        CLR = ($urandom_range(0, 11) == 0) ? NCH'($urandom) : '0;
        LOAD = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
        DIR = NCH'($urandom);
        SEL = NCH'($urandom);
        LOAD_VAL = (NCH*WIDTH)'($urandom);
        LIMIT = (NCH*WIDTH)'($urandom);
        BYPASS = (NCH*WIDTH)'($urandom);
        if ($urandom_range(0, 7) == 0) EN_G = ~EN_G;
        if ($urandom_range(0, 19) == 0) DIV = DIV_W'($urandom_range(0, 3));
    endtask

    initial begin
        int e1[7];
        int t1[7];
        int e2[4];
        int t2[4];
        e1 = '{1, 2, 3, 4, 5, 0, 1};
        t1 = '{0, 0, 0, 0, 0, 1, 0};
        e2 = '{1, 0, 5, 4};
        t2 = '{0, 0, 1, 0};

        RST = 1'b1;
        EN = '0; CLR = '0; LOAD = '0; DIR = '0; SEL = '1;
        LOAD_VAL = '0; LIMIT = '0; BYPASS = '0;
        DIV = 4'd3; EN_G = 1'b1;

        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rst_out", CNTR_OUT, 0);
        checkOutput("rst_tc", TC, 0);
        checkOutput("rst_ovf", OVF, 0);
        checkOutput("rst_div", CLK_OUT_DIV, 0);
        checkOutput("rst_gate", CLK_OUT_G, 0);
        checkEn = 1'b1;
        #1 RST = 1'b0;

        // DIV=3 from reset: first half-period 1 edge long, then 4-cycle phases
        for (int k = 1; k <= 28; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("dir_div_k%0d", k), CLK_OUT_DIV, ((k - 1) / 4) % 2 == 0);
            checkOutput($sformatf("dir_gate_k%0d", k), CLK_OUT_G,
                        (k >= 9 && k <= 12) || (k >= 25 && k <= 28));
            if (k == 10) #1 EN_G = 1'b0;
            if (k == 22) #1 EN_G = 1'b1;
        end

        #1;
        DIV = 4'd0;
        EN[0] = 1'b1; DIR[0] = 1'b0; LIMIT[0 +: WIDTH] = 3'd5;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("up_cnt_%0d", k), outSlice(0), e1[k]);
            checkOutput($sformatf("up_tc_%0d", k), TC[0], t1[k]);
            if (k == 2) #1 DIV = 4'd2;
        end
        checkOutput("up_ovf", OVF[0], 1);

        #1 EN[0] = 1'b0; LOAD[0] = 1'b1; LOAD_VAL[0 +: WIDTH] = 3'd2; DIR[0] = 1'b1;
        @(negedge CLK);
        checkOutput("dn_load", outSlice(0), 2);
        #1 LOAD[0] = 1'b0; EN[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("dn_cnt_%0d", k), outSlice(0), e2[k]);
            checkOutput($sformatf("dn_tc_%0d", k), TC[0], t2[k]);
        end

        #1 EN[0] = 1'b0; LOAD[0] = 1'b1; LOAD_VAL[0 +: WIDTH] = 3'd4;
        @(negedge CLK);
        checkOutput("prio_pre", outSlice(0), 4);
        #1 CLR[0] = 1'b1; EN[0] = 1'b1;
        @(negedge CLK);
        checkOutput("prio_clr_cnt", outSlice(0), 0);
        checkOutput("prio_clr_ovf", OVF[0], 0);
        #1 CLR[0] = 1'b0; LOAD_VAL[0 +: WIDTH] = 3'd3; DIR[0] = 1'b0;
        @(negedge CLK);
        checkOutput("prio_load", outSlice(0), 3);

        #1 LOAD[0] = 1'b0; LIMIT[0 +: WIDTH] = 3'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("lim0_cnt_%0d", k), outSlice(0), 0);
            checkOutput($sformatf("lim0_tc_%0d", k), TC[0], 1);
            if (k == 1) #1 DIR[0] = 1'b1;
        end

        #1 SEL[0] = 1'b0; BYPASS[0 +: WIDTH] = 3'b101; LIMIT[0 +: WIDTH] = 3'd7; DIR[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("byp_%0d", k), outSlice(0), 5);
        end
        #1 SEL[0] = 1'b1;
        @(negedge CLK);
        checkOutput("byp_run", outSlice(0), 4);

        #1 RST = 1'b1;
        #1;
        checkOutput("arst_out", CNTR_OUT, 0);
        checkOutput("arst_tc", TC, 0);
        checkOutput("arst_ovf", OVF, 0);
        checkOutput("arst_div", CLK_OUT_DIV, 0);
        checkOutput("arst_gate", CLK_OUT_G, 0);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkOutput("arst_resume", outSlice(0), 1);

        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            #1;
            applyStimulus();
            if ($urandom_range(0, 149) == 0) begin
                RST = 1'b1;
                #2 RST = 1'b0;
            end
        end

        @(negedge CLK);
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
